// File: rtl/i2c_pkg.sv
// Shared types for the I2C register target: FSM states, bus-condition codes,
// default device address.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK,
    ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
  } state_e;

  typedef enum logic [1:0] {
    COND_NONE  = 2'd0,
    COND_START = 2'd1,
    COND_STOP  = 2'd2
  } cond_e;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h54;

  // SDA edge while filtered SCL is high is a bus condition, not data.
  function automatic cond_e bus_cond(input logic scl, input logic sda_rise,
                                     input logic sda_fall);
    if (scl && sda_fall) return COND_START;
    if (scl && sda_rise) return COND_STOP;
    return COND_NONE;
  endfunction

endpackage

// File: rtl/i2c_in_filter.sv
// 2-FF synchroniser plus run-length filter for one open-drain bus line;
// emits the filtered level and one-cycle rise/fall strobes.
module i2c_in_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic                s1, s2;
  logic [FILT_LEN-2:0] hist;
  logic [FILT_LEN-1:0] win;

  assign win = {hist, s2};

  // Bus idles high, so everything resets to 1 to avoid a spurious edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      hist  <= '1;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      hist <= win[FILT_LEN-2:0];
      rise <= 1'b0;
      fall <= 1'b0;
      if (&win && !level) begin
        level <= 1'b1;
        rise  <= 1'b1;
      end else if (~|win && level) begin
        level <= 1'b0;
        fall  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-wide register file to the bus controller and,
// through a simple host port, to local logic.
module i2c_target_regs import i2c_pkg::*; #(
  parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
  parameter int         REG_NUM  = 16,
  parameter int         ADDR_W   = 4,
  parameter int         FILT_LEN = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_we,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              wr_pulse,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .din(scl_in),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .din(sda_in),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  state_e            state;
  logic [3:0]        bit_cnt;
  logic [7:0]        sh;
  logic [ADDR_W-1:0] ptr;
  logic              rw, ack_phase;
  logic [7:0]        regs [REG_NUM];
  cond_e             cond;
  logic [7:0]        rx_byte;

  assign cond    = bus_cond(scl_lvl, sda_rise, sda_fall);
  assign rx_byte = {sh[6:0], sda_lvl};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      sh         <= '0;
      ptr        <= '0;
      rw         <= 1'b0;
      ack_phase  <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      wr_pulse   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      host_rdata <= '0;
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else begin
      wr_pulse   <= 1'b0;
      host_rdata <= regs[host_addr];
      // Bus write below is later in the block, so it wins a same-cycle clash.
      if (host_we) regs[host_addr] <= host_wdata;
      if (cond == COND_START) begin
        state     <= ST_ADDR;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (cond == COND_STOP) begin
        state     <= ST_IDLE;
        busy      <= 1'b0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
      end else begin
        unique case (state)
          ST_ADDR, ST_REG, ST_WR_DATA: if (scl_rise) begin
            sh      <= rx_byte;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              if (state == ST_ADDR) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state <= ST_ADDR_ACK;
                  rw    <= rx_byte[0];
                  busy  <= 1'b1;
                end else begin
                  state <= ST_IGNORE;
                end
              end else if (state == ST_REG) begin
                ptr   <= rx_byte[ADDR_W-1:0];
                state <= ST_REG_ACK;
              end else begin
                regs[ptr] <= rx_byte;
                wr_pulse  <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= rx_byte;
                ptr       <= ptr + 1'b1;
                state     <= ST_WR_ACK;
              end
            end
          end
          ST_ADDR_ACK, ST_REG_ACK, ST_WR_ACK: if (scl_fall) begin
            ack_phase <= ~ack_phase;
            if (!ack_phase) begin
              sda_oe <= 1'b1;
            end else if (state == ST_ADDR_ACK && rw) begin
              // First read bit must already be on the bus at this fall.
              state  <= ST_RD_DATA;
              sda_oe <= ~regs[ptr][7];
              sh     <= {regs[ptr][6:0], 1'b0};
            end else begin
              sda_oe <= 1'b0;
              state  <= (state == ST_ADDR_ACK) ? ST_REG : ST_WR_DATA;
            end
          end
          ST_RD_DATA: begin
            if (scl_rise) bit_cnt <= bit_cnt + 1'b1;
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                ptr     <= ptr + 1'b1;
                state   <= ST_RD_ACK;
              end else begin
                sda_oe <= ~sh[7];
                sh     <= {sh[6:0], 1'b0};
              end
            end
          end
          ST_RD_ACK: if (scl_rise) begin
            if (!sda_lvl) begin
              sh    <= regs[ptr];
              state <= ST_RD_DATA;
            end else begin
              state <= ST_IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
